rotate_aligner: RTL and testbench

Receive-side counterpart to the datapath byte rotator. Accepts a word whose bit alignment has been disturbed by an unknown number of single-bit rotations, plus the expected reference pattern. Rotates the word one position per cycle, in a selected direction, until it matches the pattern, then reports the realigned word and the rotation count over a valid/ready output handshake. Sits between the rotator output and downstream consumers that need byte-aligned data.

---
 rtl/rotate_aligner.sv | 105 ++++++++++
 tb/tb_rotate_aligner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rotate_aligner.sv
// rotate_aligner: rotates a misaligned word one bit per cycle until it
// matches a reference pattern. The realigned word and the rotation count
// are then offered over a valid/ready handshake.
module rotate_aligner #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] pattern,
   input  logic             dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] aligned,
   output logic [CW-1:0]    shift_amt,
   output logic             found
);

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      DONE
   } state_t;

   // Last rotation count worth testing; one more step would wrap back to the start.
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] orig;
   logic [WIDTH-1:0] pat;
   logic             dir_q;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rotated;

   // Handshake flags follow directly from the registered state.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Next candidate alignment: one bit in the direction captured at acceptance.
   always_comb begin
      rotated = work;
      if (dir_q) begin
         rotated = {work[0], work[WIDTH-1:1]};
      end else begin
         rotated = {work[WIDTH-2:0], work[WIDTH-1]};
      end
   end

   // Control FSM: capture the request, test one rotation per cycle, then hold the result until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         work      <= '0;
         orig      <= '0;
         pat       <= '0;
         dir_q     <= 1'b0;
         count     <= '0;
         aligned   <= '0;
         shift_amt <= '0;
         found     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work  <= data_in;
                  orig  <= data_in;
                  pat   <= pattern;
                  dir_q <= dir;
                  count <= '0;
                  state <= SEARCH;
               end
            end
            SEARCH: begin
               if (work == pat) begin
                  aligned   <= work;
                  shift_amt <= count;
                  found     <= 1'b1;
                  state     <= DONE;
               end else if (count == LAST) begin
                  aligned   <= orig;
                  shift_amt <= '0;
                  found     <= 1'b0;
                  state     <= DONE;
               end else begin
                  work  <= rotated;
                  count <= count + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rotate_aligner.sv
// Testbench for rotate_aligner: table-driven requests with expected results
// queued on a scoreboard, plus hand-written backpressure and reset sequences.
module tb_rotate_aligner;

   localparam int WIDTH = 8;
   localparam int CW    = 3;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] pattern;
   logic             dir;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] aligned;
   logic [CW-1:0]    shift_amt;
   logic             found;

   typedef struct {
      logic [WIDTH-1:0] aligned;
      int               shift;
      logic             found;
      int               latency;
   } exp_t;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] pat;
      logic             dir;
      exp_t             exp;
   } vec_t;

   exp_t sbq[$];
   vec_t vecs[12];

   int nVectors  = 0;
   int nMismatch = 0;

   rotate_aligner #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .pattern   (pattern),
      .dir       (dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .aligned   (aligned),
      .shift_amt (shift_amt),
      .found     (found)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cmp(input string name, input int act, input int exp);
      nVectors++;
      if (act != exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Present one request and let it be accepted on the next rising edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] p,
                                input logic dr, input exp_t e, input bit push);
      data_in  = d;
      pattern  = p;
      dir      = dr;
      in_valid = 1'b1;
      cmp("in_ready_before_accept", int'(in_ready), 1);
      if (push) sbq.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_in  = 8'($urandom);
      pattern  = 8'($urandom);
      dir      = 1'($urandom);
   endtask

   // Wait for the result, compare it with the scoreboard, optionally stall, then retire it.
   task automatic checkOutput(input int hold);
      exp_t e;
      int   lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (sbq.size() == 0) begin
         cmp("scoreboard_empty", 1, 0);
         return;
      end
      e = sbq.pop_front();
      cmp("out_valid", int'(out_valid), 1);
      cmp("latency", lat, e.latency);
      cmp("aligned", int'(aligned), int'(e.aligned));
      cmp("shift_amt", int'(shift_amt), e.shift);
      cmp("found", int'(found), int'(e.found));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         data_in  = 8'hFF;
         pattern  = 8'hFF;
         @(posedge clk);
         #1;
         cmp("hold_out_valid", int'(out_valid), 1);
         cmp("hold_in_ready", int'(in_ready), 0);
         cmp("hold_aligned", int'(aligned), int'(e.aligned));
         cmp("hold_shift_amt", int'(shift_amt), e.shift);
         cmp("hold_found", int'(found), int'(e.found));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      cmp("out_valid_after_take", int'(out_valid), 0);
      cmp("in_ready_after_take", int'(in_ready), 1);
   endtask

   function automatic exp_t mk(input logic [WIDTH-1:0] a, input int s, input logic f, input int l);
      exp_t e;
      e.aligned = a;
      e.shift   = s;
      e.found   = f;
      e.latency = l;
      return e;
   endfunction

   // Main test sequence.
   initial begin
      exp_t e;
      vecs[0]  = '{8'h2D, 8'hA5, 1'b1, mk(8'hA5, 3, 1'b1, 4)};
      vecs[1]  = '{8'h01, 8'h80, 1'b0, mk(8'h80, 7, 1'b1, 8)};
      vecs[2]  = '{8'h03, 8'h05, 1'b0, mk(8'h03, 0, 1'b0, 8)};
      vecs[3]  = '{8'h55, 8'h55, 1'b0, mk(8'h55, 0, 1'b1, 1)};
      vecs[4]  = '{8'h01, 8'h80, 1'b1, mk(8'h80, 1, 1'b1, 2)};
      vecs[5]  = '{8'h2D, 8'hA5, 1'b0, mk(8'hA5, 5, 1'b1, 6)};
      vecs[6]  = '{8'h0F, 8'hF0, 1'b0, mk(8'hF0, 4, 1'b1, 5)};
      vecs[7]  = '{8'hFF, 8'h00, 1'b0, mk(8'hFF, 0, 1'b0, 8)};
      vecs[8]  = '{8'h81, 8'h03, 1'b0, mk(8'h03, 1, 1'b1, 2)};
      vecs[9]  = '{8'h81, 8'hC0, 1'b1, mk(8'hC0, 1, 1'b1, 2)};
      vecs[10] = '{8'h00, 8'h00, 1'b1, mk(8'h00, 0, 1'b1, 1)};
      vecs[11] = '{8'h96, 8'hA5, 1'b1, mk(8'hA5, 2, 1'b1, 3)};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      pattern   = '0;
      dir       = 1'b0;
      #1;
      cmp("reset_in_ready", int'(in_ready), 1);
      cmp("reset_out_valid", int'(out_valid), 0);
      cmp("reset_aligned", int'(aligned), 0);
      cmp("reset_shift_amt", int'(shift_amt), 0);
      cmp("reset_found", int'(found), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].data, vecs[i].pat, vecs[i].dir, vecs[i].exp, 1'b1);
         checkOutput(0);
      end

      // Backpressure: result held for five cycles while an unrelated request is offered.
      applyStimulus(8'h2D, 8'hA5, 1'b1, mk(8'hA5, 3, 1'b1, 4), 1'b1);
      checkOutput(5);
      applyStimulus(8'h01, 8'h80, 1'b0, mk(8'h80, 7, 1'b1, 8), 1'b1);
      checkOutput(0);

      // Reset two cycles into a search drops the transaction.
      e = mk(8'h80, 7, 1'b1, 8);
      applyStimulus(8'h01, 8'h80, 1'b0, e, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      cmp("midrst_out_valid", int'(out_valid), 0);
      cmp("midrst_in_ready", int'(in_ready), 1);
      cmp("midrst_aligned", int'(aligned), 0);
      cmp("midrst_shift_amt", int'(shift_amt), 0);
      cmp("midrst_found", int'(found), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         cmp("postrst_no_result", int'(out_valid), 0);
      end
      applyStimulus(8'h2D, 8'hA5, 1'b1, mk(8'hA5, 3, 1'b1, 4), 1'b1);
      checkOutput(0);

      cmp("scoreboard_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMismatch);
      $finish;
   end

endmodule
